// File: rtl/exec_dispatch.sv
// rtl/exec_dispatch.sv - instruction sequencer: fetch, decode, one-hot execute start, done wait, bus ownership
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   run                 level, keep issuing instructions while high
//   ir[15:0]            fetched instruction: [15:12] opcode, [11:6] para1, [5:0] para2
//   res*                done levels from fetch / alu / move / movi / load / store FSMs
//   <x>Wemm/Remm/Wreg/Rreg  per-FSM bus control vectors
//   startFetch          one-cycle fetch start
//   nextFSM[6:0]        one-cycle one-hot execute start
//   para1, para2        operand fields latched at fetch completion
//   bus*                control vectors of the FSM that currently owns the bus (zero when none)
//   busy, halt, illegal, timeout, instrCount  status
module exec_dispatch #(
    parameter int TIMER_W = 8,
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        resFetch,
    input  logic        resAlu,
    input  logic        resMove,
    input  logic        resMovi,
    input  logic        resLoad,
    input  logic        resStore,
    input  logic [2:0]  fetchWemm,
    input  logic [2:0]  fetchRemm,
    input  logic [3:0]  fetchWreg,
    input  logic [3:0]  fetchRreg,
    input  logic [2:0]  aluWemm,
    input  logic [2:0]  aluRemm,
    input  logic [3:0]  aluWreg,
    input  logic [3:0]  aluRreg,
    input  logic [2:0]  moveWemm,
    input  logic [2:0]  moveRemm,
    input  logic [3:0]  moveWreg,
    input  logic [3:0]  moveRreg,
    input  logic [2:0]  moviWemm,
    input  logic [2:0]  moviRemm,
    input  logic [3:0]  moviWreg,
    input  logic [3:0]  moviRreg,
    input  logic [2:0]  loadWemm,
    input  logic [2:0]  loadRemm,
    input  logic [3:0]  loadWreg,
    input  logic [3:0]  loadRreg,
    input  logic [2:0]  storeWemm,
    input  logic [2:0]  storeRemm,
    input  logic [3:0]  storeWreg,
    input  logic [3:0]  storeRreg,
    output logic        startFetch,
    output logic [6:0]  nextFSM,
    output logic [5:0]  para1,
    output logic [5:0]  para2,
    output logic [2:0]  busWemm,
    output logic [2:0]  busRemm,
    output logic [3:0]  busWreg,
    output logic [3:0]  busRreg,
    output logic        busy,
    output logic        halt,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] instrCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_START, S_FETCH_WAIT, S_DECODE, S_EXEC_START, S_EXEC_WAIT, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OWN_NONE, OWN_FETCH, OWN_ALU, OWN_MOVE, OWN_MOVI, OWN_LOAD, OWN_STORE
    } owner_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [5:0]         para1_q, para1_d;
    logic [5:0]         para2_q, para2_d;
    logic [15:0]        count_q, count_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic [6:0]         exec_code;
    owner_t             exec_owner;
    logic               exec_done;
    owner_t             owner;

    // Decode of the latched opcode; a zero code marks an illegal opcode.
    always_comb begin
        exec_code = 7'b0;
        case (opcode_q)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: exec_code = 7'b0000001;
            4'h8, 4'h9:                         exec_code = 7'b0000010;
            4'h7:                               exec_code = 7'b0000100;
            4'hA:                               exec_code = 7'b0001000;
            4'hB:                               exec_code = 7'b0010000;
            4'hC:                               exec_code = 7'b0100000;
            4'hD:                               exec_code = 7'b1000000;
            default:                            exec_code = 7'b0;
        endcase

        // All three ALU flavours report through resAlu.
        exec_owner = OWN_NONE;
        if (exec_code[2:0] != 3'b0) exec_owner = OWN_ALU;
        else if (exec_code[3])      exec_owner = OWN_MOVE;
        else if (exec_code[4])      exec_owner = OWN_MOVI;
        else if (exec_code[5])      exec_owner = OWN_LOAD;
        else if (exec_code[6])      exec_owner = OWN_STORE;

        case (exec_owner)
            OWN_ALU:   exec_done = resAlu;
            OWN_MOVE:  exec_done = resMove;
            OWN_MOVI:  exec_done = resMovi;
            OWN_LOAD:  exec_done = resLoad;
            OWN_STORE: exec_done = resStore;
            default:   exec_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            opcode_q  <= 4'h0;
            para1_q   <= 6'h0;
            para2_q   <= 6'h0;
            count_q   <= 16'h0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            opcode_q  <= opcode_d;
            para1_q   <= para1_d;
            para2_q   <= para2_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        opcode_d  = opcode_q;
        para1_d   = para1_q;
        para2_d   = para2_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_START;
            end
            S_FETCH_START: begin
                timer_d = '0;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // timer_q == 0 blanks a done level left over from the previous access.
                if (resFetch && timer_q != '0) begin
                    opcode_d = ir[15:12];
                    para1_d  = ir[11:6];
                    para2_d  = ir[5:0];
                    state_d  = S_DECODE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                if (exec_code != 7'b0) begin
                    state_d = S_EXEC_START;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC_START: begin
                timer_d = '0;
                state_d = S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (exec_done && timer_q != '0) begin
                    count_d = count_q + 16'd1;
                    state_d = run ? S_FETCH_START : S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        startFetch = (state_q == S_FETCH_START);
        nextFSM    = (state_q == S_EXEC_START) ? exec_code : 7'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_HALT);
        halt       = (state_q == S_HALT);

        case (state_q)
            S_FETCH_START, S_FETCH_WAIT: owner = OWN_FETCH;
            S_EXEC_START, S_EXEC_WAIT:   owner = exec_owner;
            default:                     owner = OWN_NONE;
        endcase

        case (owner)
            OWN_FETCH: {busWemm, busRemm, busWreg, busRreg} = {fetchWemm, fetchRemm, fetchWreg, fetchRreg};
            OWN_ALU:   {busWemm, busRemm, busWreg, busRreg} = {aluWemm, aluRemm, aluWreg, aluRreg};
            OWN_MOVE:  {busWemm, busRemm, busWreg, busRreg} = {moveWemm, moveRemm, moveWreg, moveRreg};
            OWN_MOVI:  {busWemm, busRemm, busWreg, busRreg} = {moviWemm, moviRemm, moviWreg, moviRreg};
            OWN_LOAD:  {busWemm, busRemm, busWreg, busRreg} = {loadWemm, loadRemm, loadWreg, loadRreg};
            OWN_STORE: {busWemm, busRemm, busWreg, busRreg} = {storeWemm, storeRemm, storeWreg, storeRreg};
            default:   {busWemm, busRemm, busWreg, busRreg} = 14'b0;
        endcase
    end

    assign para1      = para1_q;
    assign para2      = para2_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;
    assign instrCount = count_q;

endmodule
